// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the prefetching fetch stage.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int ILEN_BYTES = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetch entries; flush beats push and pop.
module fetch_queue import fetch_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  fetch_entry_t             push_data_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        rd_ptr_d = flush_i ? '0 : pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = flush_i ? '0 : push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = flush_i ? '0 : count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
endmodule

// File: rtl/fetch_stage_pfb.sv
// fetch_stage_pfb: credit-based prefetching fetch stage with redirect flush.
// Define FETCH_PERF_EN to add saturating empty-cycle and flush counters.
module fetch_stage_pfb import fetch_pkg::*; #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] irdata_i,
    output logic [31:0] iaddr_o,
    output logic        ird_o,
    input  logic        branch_taken_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ex_stall_i,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_empty_cnt_o,
    output logic [31:0] perf_flush_cnt_o,
`endif
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_next_pc_o
);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t   head, resp_entry, entry;
    logic [PTR_W:0] count;
    logic           empty, full, resp, push, pop, q_pop;
    logic [31:0]    fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic           inflight_q, inflight_d, drop_q, drop_d;
    logic           unused_jump_lsb;

    assign unused_jump_lsb = ^jump_addr_i[1:0];

    // An arriving response bypasses an empty queue so the head is valid on the data cycle.
    always_comb begin
        resp         = reset_i & inflight_q & ~drop_q;
        resp_entry   = {req_pc_q, irdata_i};
        ird_o        = reset_i & ~branch_taken_i & ~full &
                       ((32'(count) + 32'(inflight_q)) < 32'(DEPTH));
        if_valid_o   = ~empty | resp;
        entry        = empty ? resp_entry : head;
        pop          = if_valid_o & ~ex_stall_i & ~branch_taken_i;
        q_pop        = pop & ~empty;
        push         = resp & ~(empty & pop);
        if_pc_o      = if_valid_o ? entry.pc : '0;
        if_instr_o   = if_valid_o ? entry.instr : '0;
        if_next_pc_o = if_valid_o ? entry.pc + 32'(ILEN_BYTES) : '0;
        fetch_pc_d   = branch_taken_i ? {jump_addr_i[31:2], 2'b00} :
                       ird_o ? fetch_pc_q + 32'(ILEN_BYTES) : fetch_pc_q;
        req_pc_d     = ird_o ? fetch_pc_q : req_pc_q;
        inflight_d   = ird_o;
        drop_d       = branch_taken_i & inflight_q;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    assign iaddr_o = fetch_pc_q;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (push),
        .pop_i       (q_pop),
        .flush_i     (branch_taken_i),
        .push_data_i (resp_entry),
        .head_o      (head),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (full)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_empty_cnt_q, perf_empty_cnt_d, perf_flush_cnt_q, perf_flush_cnt_d;

    always_comb begin
        perf_empty_cnt_d = (~if_valid_o & ~ex_stall_i & (perf_empty_cnt_q != '1)) ?
                           perf_empty_cnt_q + 32'd1 : perf_empty_cnt_q;
        perf_flush_cnt_d = (branch_taken_i & (perf_flush_cnt_q != '1)) ?
                           perf_flush_cnt_q + 32'd1 : perf_flush_cnt_q;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            perf_empty_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            perf_empty_cnt_q <= perf_empty_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_empty_cnt_o = perf_empty_cnt_q;
    assign perf_flush_cnt_o = perf_flush_cnt_q;
`endif
endmodule
